// File: rtl/jk_pkg.sv
// Shared types and JK excitation codes for the JK flip-flop bank driver.
// Codes are packed as {j, k}; the toggle code 2'b11 is never produced.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_RESET = 2'b01;
  localparam logic [1:0] JK_SET   = 2'b10;

  // Wide enough for the full legal SETTLE range of 1..15.
  localparam int CNT_W = 4;

  // Forced encoding ignores cur so the bit lands on tgt whatever the bank holds.
  function automatic logic [1:0] jk_encode(input logic cur, input logic tgt, input logic frc);
    if (!frc && (cur == tgt)) begin
      return JK_HOLD;
    end
    return tgt ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation encoder: purely combinational, one instance per bank bit.
module jk_excite
  import jk_pkg::*;
(
  input  logic cur,
  input  logic tgt,
  input  logic frc,
  output logic j,
  output logic k
);

  logic [1:0] code;

  always_comb begin
    code = jk_encode(cur, tgt, frc);
    j    = code[1];
    k    = code[0];
  end

endmodule

// File: rtl/jk_driver.sv
// Drives a JK flip-flop bank to a target word, waits SETTLE cycles and checks readback.
// Fixed latency SETTLE+3 cycles per word; tgt_ready is high only while idle.
module jk_driver
  import jk_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             mismatch,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] shadow;
  logic             shadow_vld;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;
  logic             frc;
  logic             rb_diff;

  // Without a trusted copy of the bank contents every bit must be driven explicitly.
  assign frc     = !shadow_vld;
  assign rb_diff = (q_fb != tgt_r);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite u_excite (
      .cur (shadow[i]),
      .tgt (tgt_r[i]),
      .frc (frc),
      .j   (enc_j[i]),
      .k   (enc_k[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tgt_r      <= '0;
      shadow     <= '0;
      shadow_vld <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (tgt_valid) begin
            tgt_r <= tgt_data;
          end
        end
        ST_APPLY: begin
          cnt <= CNT_W'(SETTLE);
        end
        ST_SETTLE: begin
          cnt <= cnt - CNT_W'(1);
        end
        ST_CHECK: begin
          // A failed readback means the bank state is unknown; re-force next time.
          shadow     <= tgt_r;
          shadow_vld <= !rb_diff;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_ready = 1'b0;
    j         = '0;
    k         = '0;
    done      = 1'b0;
    mismatch  = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        j         = enc_j;
        // Masking k with ~j keeps the toggle code off the bank even if the encoder is wrong.
        k         = enc_k & ~enc_j;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        done      = 1'b1;
        mismatch  = rb_diff;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: JK bank model with stuck-at injection, vector table, corner sequences, random traffic.
module tb_jk_driver;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_fb;
  logic             done;
  logic             mismatch;
  logic             busy;

  logic [WIDTH-1:0] q_bank = '0;
  logic [WIDTH-1:0] s1 = '0;
  logic [WIDTH-1:0] s0 = '0;

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  // Reference knowledge: last committed target and whether it was confirmed.
  logic [WIDTH-1:0] m_prev = '0;
  bit               m_vld  = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] stuck1;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    bit               emm;
  } vec_t;

  vec_t vt[5];

  jk_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .done      (done),
    .mismatch  (mismatch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // JK characteristic equation, including toggle, so an illegal 11 would show up.
  always @(posedge clk) q_bank <= (j & ~q_bank) | (~k & q_bank);
  assign q_fb = (q_bank | s1) & ~s0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) chk("no_toggle", 32'(j & k), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (tgt_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_ready_wait"}, 32'(tgt_ready), 32'd1);
  endtask

  // Excitation the driver should emit for target t, from the committed history.
  function automatic logic [2*WIDTH-1:0] exp_jk(input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    if (!m_vld) begin
      ej = t;
      ek = ~t;
    end else begin
      ej = t & ~m_prev;
      ek = ~t & m_prev;
    end
    return {ej, ek};
  endfunction

  task automatic run_txn(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] ej,
                         input logic [WIDTH-1:0] ek, input bit emm, input string tag);
    wait_ready(tag);
    tgt_valid = 1'b1;
    tgt_data  = t;
    tick();
    tgt_valid = 1'b0;
    tgt_data  = WIDTH'($urandom);
    chk({tag, "_apply_busy"}, 32'(busy), 32'd1);
    chk({tag, "_apply_j"}, 32'(j), 32'(ej));
    chk({tag, "_apply_k"}, 32'(k), 32'(ek));
    chk({tag, "_apply_done"}, 32'(done), 32'd0);
    for (int c = 0; c < SETTLE; c++) begin
      tick();
      chk({tag, "_settle_jk"}, 32'({j, k}), 32'd0);
      chk({tag, "_settle_done"}, 32'(done), 32'd0);
      chk({tag, "_settle_ready"}, 32'(tgt_ready), 32'd0);
    end
    tick();
    chk({tag, "_check_done"}, 32'(done), 32'd1);
    chk({tag, "_check_mismatch"}, 32'(mismatch), 32'(emm));
    tick();
    chk({tag, "_idle_ready"}, 32'(tgt_ready), 32'd1);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_mismatch"}, 32'(mismatch), 32'd0);
    m_prev = t;
    m_vld  = !emm;
  endtask

  task automatic run_model_txn(input logic [WIDTH-1:0] t, input string tag);
    logic [2*WIDTH-1:0] e;
    logic [WIDTH-1:0]   nq;
    bit                 emm;
    e   = exp_jk(t);
    nq  = (e[2*WIDTH-1:WIDTH] & ~q_bank) | (~e[WIDTH-1:0] & q_bank);
    emm = (((nq | s1) & ~s0) != t);
    run_txn(t, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0], emm, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfer[$];
    int cyc;

    vt[0] = '{tgt: 4'b1010, stuck1: 4'b0000, ej: 4'b1010, ek: 4'b0101, emm: 1'b0};
    vt[1] = '{tgt: 4'b1100, stuck1: 4'b0000, ej: 4'b0100, ek: 4'b0010, emm: 1'b0};
    vt[2] = '{tgt: 4'b1100, stuck1: 4'b0000, ej: 4'b0000, ek: 4'b0000, emm: 1'b0};
    vt[3] = '{tgt: 4'b0000, stuck1: 4'b0001, ej: 4'b0000, ek: 4'b1100, emm: 1'b1};
    vt[4] = '{tgt: 4'b0001, stuck1: 4'b0001, ej: 4'b0001, ek: 4'b1110, emm: 1'b0};

    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    tick();
    tick();
    rst   = 1'b0;
    armed = 1'b1;
    chk("reset_ready", 32'(tgt_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_jk", 32'({j, k}), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mismatch", 32'(mismatch), 32'd0);
    tick();
    chk("idle_no_valid_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      s1 = vt[i].stuck1;
      run_txn(vt[i].tgt, vt[i].ej, vt[i].ek, vt[i].emm, $sformatf("vec%0d", i));
      if (i == 1) chk("vec1_bank_q", 32'(q_fb), 32'(4'b1100));
    end
    s1 = '0;

    // Reset in the middle of SETTLE aborts silently and forces the next word.
    wait_ready("rst_mid");
    tgt_valid = 1'b1;
    tgt_data  = 4'b0110;
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("rst_mid_in_settle", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready", 32'(tgt_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_jk", 32'({j, k}), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst_mid_no_done", 32'(done), 32'd0);
    end
    m_vld = 1'b0;
    run_txn(4'b0011, 4'b0011, 4'b1100, 1'b0, "after_rst");

    // Reset wins over a simultaneous offer.
    tgt_valid = 1'b1;
    tgt_data  = 4'b1111;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    tgt_valid = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_ready", 32'(tgt_ready), 32'd1);
    tick();
    chk("rst_prio_still_idle", 32'(busy), 32'd0);
    m_vld = 1'b0;

    // Held valid: transfers must be spaced SETTLE+3 cycles apart.
    tgt_valid = 1'b1;
    tgt_data  = 4'b1001;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      if (tgt_valid && tgt_ready) xfer.push_back(cyc);
      tick();
      cyc++;
    end
    tgt_valid = 1'b0;
    chk("b2b_count", 32'(xfer.size() >= 3), 32'd1);
    for (int i = 1; i < xfer.size(); i++) begin
      chk("b2b_spacing", 32'(xfer[i] - xfer[i-1]), 32'(SETTLE + 3));
    end
    wait_ready("b2b_end");
    m_prev = 4'b1001;
    m_vld  = 1'b1;

    for (int n = 0; n < 40; n++) begin
      int r;
      r  = $urandom_range(0, 3);
      s1 = '0;
      s0 = '0;
      if (r == 0) s1 = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      if (r == 1) s0 = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      repeat ($urandom_range(0, 2)) tick();
      run_model_txn(WIDTH'($urandom), "rand");
    end
    s1 = '0;
    s0 = '0;

    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_driver.md
JK_DRIVER -- requirements
Module: jk_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of JK flip-flops driven.
REQ-002 SHALL have parameter SETTLE, default 2, legal range 1..15: hold cycles between excitation and readback check.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port tgt_valid, input, 1: target word offered.
REQ-006 SHALL have port tgt_ready, output, 1: block can accept a target word.
REQ-007 SHALL have port tgt_data, input, WIDTH: desired next q of the flip-flop bank.
REQ-008 SHALL have port j, output, WIDTH: J excitation to the bank.
REQ-009 SHALL have port k, output, WIDTH: K excitation to the bank.
REQ-010 SHALL have port q_fb, input, WIDTH: q readback from the bank.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at transaction end.
REQ-012 SHALL have port mismatch, output, 1: one-cycle pulse, coincident with done, when readback differs from target.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> APPLY -> SETTLE -> CHECK -> IDLE.
REQ-015 SHALL drive tgt_ready=1 only in IDLE; transfer occurs on a posedge with tgt_valid=1 and tgt_ready=1.
REQ-016 SHALL register tgt_data on transfer and move to APPLY; with tgt_valid=0, SHALL stay in IDLE.
REQ-017 SHALL drive j/k with excitation for exactly one cycle in APPLY, then go to SETTLE.
REQ-018 SHALL use per-bit excitation when shadow valid: cur==tgt -> j=0,k=0; cur=0,tgt=1 -> j=1,k=0; cur=1,tgt=0 -> j=0,k=1.
REQ-019 SHALL never emit j=1,k=1 (toggle) in any state.
REQ-020 SHALL, when shadow invalid, force every bit: j=tgt, k=~tgt.
REQ-021 SHALL hold j=k=0 in IDLE, SETTLE and CHECK.
REQ-022 SHALL remain in SETTLE exactly SETTLE cycles, counted by a down-counter loaded on APPLY exit.
REQ-023 SHALL in CHECK (one cycle) compare q_fb to the registered target, assert done=1, and assert mismatch=1 iff any bit differs.
REQ-024 SHALL on CHECK exit load shadow with the target; set shadow valid if no mismatch, else clear it.
REQ-025 SHALL give fixed latency: transfer edge T, APPLY in cycle T+1, CHECK in cycle T+SETTLE+2, tgt_ready=1 again in cycle T+SETTLE+3.
REQ-026 SHALL ignore tgt_valid/tgt_data outside IDLE; a held tgt_valid transfers only on return to IDLE.
REQ-027 SHALL ignore q_fb outside CHECK.

Reset
REQ-028 SHALL, on rst=1 at a posedge, enter IDLE, clear shadow valid, and zero counter and target register.
REQ-029 SHALL reset outputs to j=0, k=0, done=0, mismatch=0, busy=0, tgt_ready=1 from the first cycle after reset.
REQ-030 SHALL, on reset in any state (including mid-APPLY), abort without done, and force-encode the next transaction.
REQ-031 SHALL give rst priority over a simultaneous tgt_valid: no transfer that cycle.

Structure
REQ-032 SHALL take the FSM state enumeration and excitation code constants (HOLD=00, RESET=01, SET=10) from shared package jk_pkg.
REQ-033 SHALL instantiate one sub-module, jk_excite: a purely combinational per-bit encoder (cur, tgt, force -> j, k), WIDTH copies.

Verification (bench models a WIDTH-bit JK flip-flop bank on q_fb; WIDTH=4, SETTLE=2)
REQ-034 SHALL verify: reset, then tgt_data=4'b1010 -> APPLY j=1010, k=0101 (forced), done in cycle T+4, mismatch=0.
REQ-035 SHALL verify: after 1010, tgt_data=4'b1100 -> j=0100, k=0010, bank q=1100, mismatch=0.
REQ-036 SHALL verify: same target 1100 repeated -> j=k=0000 in APPLY, done=1, mismatch=0.
REQ-037 SHALL verify: bank bit0 stuck at 1, target 0000 -> mismatch=1 with done; next target 0001 force-encoded: j=0001, k=1110.
REQ-038 SHALL verify: rst asserted during SETTLE -> no done, j=k=0, tgt_ready=1 next cycle; next target force-encoded.
REQ-039 SHALL verify: tgt_valid held high back-to-back -> transfers spaced exactly SETTLE+3 = 5 cycles; j&k==0 on every cycle.
